// File: rtl/lc_mem_ctrl.sv
// Word-addressed memory behind an asynchronous four-phase request/acknowledge
// handshake; optional extra access latency set by WAIT_CYCLES.
`ifndef LC_MEM_DEPTH
`define LC_MEM_DEPTH 16
`endif
`ifndef LC_MEM_ADDR_WIDTH
`define LC_MEM_ADDR_WIDTH 8
`endif
`ifndef LC_MEM_DATA_WIDTH
`define LC_MEM_DATA_WIDTH 32
`endif

module lc_mem_ctrl #(
    parameter int MEM_DEPTH   = `LC_MEM_DEPTH,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                            CLK,
    input  logic                            RESETn,
    input  logic                            MEM_REQ_IN,
    input  logic                            MEM_WRITE,
    input  logic [`LC_MEM_ADDR_WIDTH-3:0]   MEM_AIN,
    input  logic [`LC_MEM_DATA_WIDTH-1:0]   MEM_DIN,
    output logic                            MEM_ACK_OUT,
    output logic [`LC_MEM_DATA_WIDTH-1:0]   MEM_DOUT,
    output logic [1:0]                      DBG_STATE
);
    localparam int AW = `LC_MEM_ADDR_WIDTH - 2;
    localparam int DW = `LC_MEM_DATA_WIDTH;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        ACK      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    // Handshake: the requester raises MEM_REQ_IN with MEM_WRITE/MEM_AIN/MEM_DIN
    // stable, waits for MEM_ACK_OUT=1, then drops MEM_REQ_IN; MEM_ACK_OUT falls
    // once the synchronised request is seen low, completing the four phases.
    state_t          state, state_next;
    logic            req_meta, req_s;
    logic [3:0]      wait_cnt;
    logic            wr_r;
    logic [AW-1:0]   addr_r;
    logic [DW-1:0]   data_r;
    logic [DW-1:0]   mem [MEM_DEPTH];
    logic            in_range;
    logic            exec;
    logic [IW-1:0]   idx;

    assign in_range  = ({{(32-AW){1'b0}}, addr_r} < 32'(MEM_DEPTH));
    assign exec      = (state == ACCESS) && (wait_cnt == 4'd0);
    assign idx       = addr_r[IW-1:0];
    assign DBG_STATE = state;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req_s)              state_next = ACCESS;
            ACCESS:   if (wait_cnt == 4'd0)   state_next = ACK;
            ACK:      if (!req_s)             state_next = WAIT_LOW;
            WAIT_LOW:                         state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            req_meta    <= 1'b0;
            req_s       <= 1'b0;
            wait_cnt    <= 4'd0;
            MEM_ACK_OUT <= 1'b0;
            MEM_DOUT    <= '0;
            wr_r        <= 1'b0;
            addr_r      <= '0;
            data_r      <= '0;
        end else begin
            req_meta    <= MEM_REQ_IN;
            req_s       <= req_meta;
            MEM_ACK_OUT <= (state_next == ACK);
            if (state == IDLE && req_s) begin
                wr_r     <= MEM_WRITE;
                addr_r   <= MEM_AIN;
                data_r   <= MEM_DIN;
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (exec && !wr_r)
                MEM_DOUT <= in_range ? mem[idx] : '0;
        end
    end

    // Array is deliberately outside reset; a reset forces IDLE so a pending write never fires.
    always_ff @(posedge CLK) begin
        if (exec && wr_r && in_range)
            mem[idx] <= data_r;
    end

endmodule

// File: tb/tb_lc_mem_ctrl.sv
// Directed bench for lc_mem_ctrl: three instances (WAIT_CYCLES 0, 3, 4) driven
// through the four-phase handshake and compared against hand-computed values.
module tb_lc_mem_ctrl;
    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  wr = 3'b000;
    logic [2:0]  ack;
    logic [5:0]  ain  [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic [1:0]  st   [3];

    int n_checks = 0;
    int n_err    = 0;
    int acc_cnt [3] = '{0, 0, 0};
    logic [2:0] ack_d = 3'b000;
    logic [31:0] exp_q [$];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc_mem_ctrl #(
            .MEM_DEPTH   (16),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .CLK         (CLK),
            .RESETn      (RESETn),
            .MEM_REQ_IN  (req[g]),
            .MEM_WRITE   (wr[g]),
            .MEM_AIN     (ain[g]),
            .MEM_DIN     (din[g]),
            .MEM_ACK_OUT (ack[g]),
            .MEM_DOUT    (dout[g]),
            .DBG_STATE   (st[g])
        );
    end

    // Count acknowledge pulses per instance to catch lost or duplicated accesses.
    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++)
            if (ack[i] && !ack_d[i]) acc_cnt[i]++;
        ack_d = ack;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency is counted in edges from raising MEM_REQ_IN: 2 sync edges + WAIT_CYCLES + 2.
    task automatic do_access(input int idx, input logic w, input logic [5:0] a,
                             input logic [31:0] d, input int exp_lat,
                             input string name, output logic [31:0] rd);
        int  n;
        bit  seen;
        @(negedge CLK);
        wr[idx] = w; ain[idx] = a; din[idx] = d; req[idx] = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge CLK); #1; n++;
            if (n == 3) begin
                ain[idx] = ~a; din[idx] = ~d; wr[idx] = ~w;
            end
            if (ack[idx]) seen = 1;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        rd = dout[idx];
        @(negedge CLK); req[idx] = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge CLK); #1; n++;
            if (!ack[idx]) seen = 1;
        end
        check({name, " ack_fall"}, 32'(n), 32'd3);
    endtask

    typedef struct {
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [31:0] rd;
        int          n;
        int          cnt0;
        int          hi;

        for (int i = 0; i < 3; i++) begin
            ain[i] = '0;
            din[i] = '0;
        end

        vt[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 32'h0000_0000};
        vt[1]  = '{1'b0, 6'd5,  32'h0,        32'hDEADBEEF};
        vt[2]  = '{1'b1, 6'd0,  32'hCAFEF00D, 32'hDEADBEEF};
        vt[3]  = '{1'b1, 6'd15, 32'h0BADC0DE, 32'hDEADBEEF};
        vt[4]  = '{1'b1, 6'd16, 32'h12345678, 32'hDEADBEEF};
        vt[5]  = '{1'b0, 6'd16, 32'h0,        32'h0000_0000};
        vt[6]  = '{1'b1, 6'd63, 32'hFFFFFFFF, 32'h0000_0000};
        vt[7]  = '{1'b0, 6'd0,  32'h0,        32'hCAFEF00D};
        vt[8]  = '{1'b0, 6'd15, 32'h0,        32'h0BADC0DE};
        vt[9]  = '{1'b0, 6'd63, 32'h0,        32'h0000_0000};
        vt[10] = '{1'b0, 6'd5,  32'h0,        32'hDEADBEEF};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset ack[%0d]", i),   32'(ack[i]), 32'd0);
            check($sformatf("reset dout[%0d]", i),  dout[i],     32'd0);
            check($sformatf("reset state[%0d]", i), 32'(st[i]),  32'd0);
        end
        @(negedge CLK); RESETn = 1'b1;

        // Table of single accesses on the zero-wait instance
        cnt0 = acc_cnt[0];
        for (int i = 0; i < 11; i++) begin
            do_access(0, vt[i].w, vt[i].a, vt[i].d, 4, $sformatf("vec%0d", i), rd);
            check($sformatf("vec%0d dout", i), rd, vt[i].exp_dout);
        end
        check("table access count", 32'(acc_cnt[0] - cnt0), 32'd11);

        // Request withdrawn before ACK: access still completes, ACK lasts one cycle
        cnt0 = acc_cnt[0];
        @(negedge CLK);
        wr[0] = 1'b1; ain[0] = 6'd7; din[0] = 32'h0000_0077; req[0] = 1'b1;
        repeat (2) @(posedge CLK);
        #1; req[0] = 1'b0;
        n = 2; hi = 0;
        while (!ack[0] && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        check("early drop latency", 32'(n), 32'd4);
        @(posedge CLK); #1;
        check("early drop ack one cycle", 32'(ack[0]), 32'd0);
        do_access(0, 1'b0, 6'd7, 32'h0, 4, "early drop readback", rd);
        check("early drop readback dout", rd, 32'h0000_0077);
        check("early drop access count", 32'(acc_cnt[0] - cnt0), 32'd2);

        // Held request: ACK stays high, single access, falls 3 edges after drop
        cnt0 = acc_cnt[0];
        @(negedge CLK);
        wr[0] = 1'b0; ain[0] = 6'd5; req[0] = 1'b1;
        n = 0;
        while (!ack[0] && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        check("hold latency", 32'(n), 32'd4);
        hi = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (ack[0]) hi++;
        end
        check("hold ack cycles", 32'(hi), 32'd10);
        @(negedge CLK); req[0] = 1'b0;
        n = 0;
        while (ack[0] && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        check("hold ack_fall", 32'(n), 32'd3);
        repeat (8) @(posedge CLK);
        #1;
        check("hold no second access", 32'(acc_cnt[0] - cnt0), 32'd1);
        check("hold back to idle", 32'(st[0]), 32'd0);

        // Back-to-back alternating write/read on words 0..7
        cnt0 = acc_cnt[0];
        for (int i = 0; i < 8; i++) begin
            logic [31:0] wd;
            wd = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            exp_q.push_back(wd);
            do_access(0, 1'b1, 6'(i), wd, 4, $sformatf("b2b wr%0d", i), rd);
            do_access(0, 1'b0, 6'(i), 32'h0, 4, $sformatf("b2b rd%0d", i), rd);
            check($sformatf("b2b readback%0d", i), rd, exp_q.pop_front());
        end
        check("b2b access count", 32'(acc_cnt[0] - cnt0), 32'd16);

        // WAIT_CYCLES=3: ACK 5 cycles after req_s rises
        do_access(1, 1'b1, 6'd0, 32'h3333_0000, 7, "wait3 write", rd);
        do_access(1, 1'b0, 6'd0, 32'h0, 7, "wait3 read", rd);
        check("wait3 read dout", rd, 32'h3333_0000);

        // WAIT_CYCLES=4: reset during ACCESS abandons the write
        do_access(2, 1'b1, 6'd2, 32'h1111_1111, 8, "wait4 pre write", rd);
        do_access(2, 1'b0, 6'd2, 32'h0, 8, "wait4 pre read", rd);
        check("wait4 pre read dout", rd, 32'h1111_1111);
        @(negedge CLK);
        wr[2] = 1'b1; ain[2] = 6'd2; din[2] = 32'hA5A5A5A5; req[2] = 1'b1;
        n = 0;
        while (st[2] != 2'd1 && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        check("wait4 reach ACCESS", 32'(n), 32'd3);
        #2 RESETn = 1'b0;
        #1;
        check("midreset ack", 32'(ack[2]), 32'd0);
        check("midreset state", 32'(st[2]), 32'd0);
        check("midreset dout", dout[2], 32'd0);
        req[2] = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RESETn = 1'b1;
        do_access(2, 1'b0, 6'd2, 32'h0, 8, "post reset read", rd);
        check("post reset read dout", rd, 32'h1111_1111);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lc_mem_ctrl.md
LC_MEM_CTRL -- requirements
Module: lc_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default `LC_MEM_DEPTH, number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, extra access-latency cycles, range 0-15.
REQ-003 CLK  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 RESETn  input  1  reset, asynchronous and active-low.
REQ-005 MEM_REQ_IN  input  1  access request from the layer controller; asynchronous to this block.
REQ-006 MEM_WRITE  input  1  1 = write, 0 = read; valid while MEM_REQ_IN=1.
REQ-007 MEM_AIN  input  `LC_MEM_ADDR_WIDTH-2  word address; valid while MEM_REQ_IN=1.
REQ-008 MEM_DIN  input  `LC_MEM_DATA_WIDTH  write data; valid while MEM_REQ_IN=1.
REQ-009 MEM_ACK_OUT  output  1  access-complete acknowledge.
REQ-010 MEM_DOUT  output  `LC_MEM_DATA_WIDTH  read data; valid while MEM_ACK_OUT=1 after a read.

Function
REQ-011 MEM_REQ_IN SHALL be double-latched (two flops) before use; req_s denotes the second-stage output.
REQ-012 The FSM SHALL have the states IDLE, ACCESS, ACK and WAIT_LOW.
REQ-013 In IDLE with req_s=1, the FSM SHALL capture MEM_WRITE, MEM_AIN and MEM_DIN into local registers, load wait_cnt=WAIT_CYCLES and move to ACCESS.
REQ-014 In ACCESS with wait_cnt>0, wait_cnt SHALL decrement by 1 per cycle; with wait_cnt=0 the op SHALL execute and the FSM SHALL move to ACK.
REQ-015 A write executed with addr<MEM_DEPTH SHALL store the captured data at that word; MEM_DOUT SHALL stay unchanged.
REQ-016 A read executed with addr<MEM_DEPTH SHALL register the array word into MEM_DOUT in the same edge that enters ACK.
REQ-017 An out-of-range address (addr>=MEM_DEPTH) SHALL be acknowledged normally; a write SHALL be discarded with the array unchanged, and a read SHALL return MEM_DOUT=0.
REQ-018 MEM_ACK_OUT SHALL be registered and equal 1 exactly while the FSM is in ACK.
REQ-019 In ACK with req_s=0, MEM_ACK_OUT SHALL drop on the next edge and the FSM SHALL move to WAIT_LOW; in ACK with req_s=1 the FSM SHALL hold (four-phase handshake).
REQ-020 WAIT_LOW SHALL last exactly one cycle and then move to IDLE, preventing re-trigger on a stale req_s.
REQ-021 With WAIT_CYCLES=0, the latency from a req_s rising edge to MEM_ACK_OUT=1 SHALL be 2 cycles; the general latency is WAIT_CYCLES+2.
REQ-022 Changes on MEM_AIN, MEM_DIN or MEM_WRITE after capture SHALL have no effect on the current access.
REQ-023 A MEM_REQ_IN deassertion before ACK SHALL NOT abort the access; the access SHALL complete, ACK SHALL assert, and ACK SHALL drop on the following cycle because req_s=0.
REQ-024 MEM_DOUT SHALL hold its value between accesses.
REQ-025 Array contents SHALL NOT be affected by reset.

Reset
REQ-026 On RESETn=0, independent of CLK, the following SHALL apply: FSM=IDLE, sync flops=0, wait_cnt=0, MEM_ACK_OUT=0, MEM_DOUT=0, captured address/data/write=0.
REQ-027 A reset asserted mid-access (ACCESS or ACK) SHALL abandon the operation; a write not yet executed SHALL leave the array unchanged.
REQ-028 After RESETn rises, the block SHALL accept a new request only once req_s=1, i.e. at least 2 edges later.

Verification
REQ-029 The bench SHALL cover write then read: WAIT_CYCLES=0, write addr 5 data 0xDEADBEEF, then read addr 5 -> MEM_DOUT=0xDEADBEEF with ACK 2 cycles after req_s rises.
REQ-030 The bench SHALL cover latency: WAIT_CYCLES=3, read addr 0 -> MEM_ACK_OUT rises exactly 5 cycles after req_s rises.
REQ-031 The bench SHALL cover out of range: write addr MEM_DEPTH data 0x12345678, then read addr MEM_DEPTH -> MEM_DOUT=0, with both accesses acknowledged and word 0 and word MEM_DEPTH-1 unchanged.
REQ-032 The bench SHALL cover the handshake: hold MEM_REQ_IN=1 for 10 cycles after ACK -> ACK stays 1; drop REQ -> ACK falls 3 edges later (2 sync + 1); no second access occurs.
REQ-033 The bench SHALL cover back-to-back requests: alternating write/read on addrs 0..7 with REQ re-raised immediately after ACK falls -> all 8 readbacks match and no access is duplicated or lost.
REQ-034 The bench SHALL cover reset mid-access: WAIT_CYCLES=4, write addr 2 data 0xA5A5A5A5, assert RESETn=0 during ACCESS -> MEM_ACK_OUT=0 immediately, and a subsequent read of addr 2 returns its prior value.
